// File: rtl/encoder8_3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and emits one index per handshake.
// Define ENC_ROUND_ROBIN_EN for round-robin order; default is highest-index-first priority.
module encoder8_3_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] d,
    input  logic       ready,
    output logic [2:0] y,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] cnt
);

    typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pend,  w_pend_nxt;
    logic [2:0] r_ptr,   w_ptr_nxt;
    logic [2:0] r_y,     w_y_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [7:0] w_pend_clr;
    logic       w_hs;

`ifdef ENC_ROUND_ROBIN_EN
    // Ascending search starting just after the last emitted index, wrapping at 8.
    function automatic logic [2:0] f_select(input logic [7:0] vec, input logic [2:0] ptr);
        logic [2:0] sel;
        logic [2:0] idx;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && vec[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction
`else
    function automatic logic [2:0] f_select(input logic [7:0] vec, input logic [2:0] ptr);
        logic [2:0] sel;
        sel = ptr ^ ptr;
        for (int unsigned k = 0; k < 8; k++) begin
            if (vec[k]) sel = 3'(k);
        end
        return sel;
    endfunction
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_ptr_nxt   = r_ptr;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_pend_clr  = r_pend & ~(8'b1 << r_y);
        w_hs        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load && en) begin
                    w_cnt_nxt = '0;
                    if (d != '0) begin
                        w_pend_nxt  = d;
                        w_busy_nxt  = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_y_nxt     = f_select(d, r_ptr);
                        w_state_nxt = S_SEND;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // en gates the handshake so a paused block never consumes an index.
                w_hs = r_valid && ready && en;
                if (w_hs) begin
                    w_pend_nxt = w_pend_clr;
                    w_ptr_nxt  = r_y;
                    w_cnt_nxt  = r_cnt + 4'd1;
                    if (w_pend_clr != '0) begin
                        w_y_nxt     = f_select(w_pend_clr, r_y);
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_valid_nxt = en && (r_pend != '0);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_ptr   <= '1;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_ptr   <= w_ptr_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;
    assign cnt   = r_cnt;

endmodule

// File: tb/tb_encoder8_3_seq.sv
// Directed bench for encoder8_3_seq; expected orders follow ENC_ROUND_ROBIN_EN.
module tb_encoder8_3_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] d;
    logic       ready;
    logic [2:0] y;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    encoder8_3_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .load  (load),
        .d     (d),
        .ready (ready),
        .y     (y),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        ready = 1'b0;
        d     = 8'h00;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    // Loads vec with ready held high and records every accepted index until done.
    task automatic drain(input logic [7:0] vec, output logic [23:0] seq, output int n);
        seq  = '0;
        n    = 0;
        en   = 1'b1;
        ready = 1'b1;
        load = 1'b1;
        d    = vec;
        tick();
        load = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (valid && ready && n < 8) begin
                seq[3*n +: 3] = y;
                n++;
            end
            tick();
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0; load = 1'b0; ready = 1'b0; d = 8'h00;
        #3;
        vectors++;
        if ({y, valid, busy, done, cnt} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset: got y=%0d v=%0b b=%0b d=%0b c=%0d want all zero", y, valid, busy, done, cnt);
        end
        do_reset();
    endtask

    task automatic test_basic;
        logic [2:0] exp_a [3];
`ifdef ENC_ROUND_ROBIN_EN
        exp_a = '{3'd2, 3'd5, 3'd7};
`else
        exp_a = '{3'd7, 3'd5, 3'd2};
`endif
        do_reset();
        en = 1'b1; ready = 1'b1; load = 1'b1; d = 8'b1010_0100;
        tick();
        load = 1'b0;
        vectors++;
        if (!(valid === 1'b1 && busy === 1'b1)) begin
            miscompares++;
            $display("FAIL basic_latency: got valid=%0b busy=%0b want 1 1", valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (y !== exp_a[i] || valid !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_y%0d: got y=%0d valid=%0b want y=%0d valid=1", i, y, valid, exp_a[i]);
            end
            tick();
        end
        vectors++;
        if ({done, valid, busy, cnt} !== {1'b1, 1'b0, 1'b0, 4'd3}) begin
            miscompares++;
            $display("FAIL basic_done: got done=%0b valid=%0b busy=%0b cnt=%0d want 1 0 0 3", done, valid, busy, cnt);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got done=%0b cnt=%0d want 0 3", done, cnt);
        end
    endtask

    task automatic test_zero_load;
        en = 1'b0; load = 1'b1; d = 8'hFF;
        tick();
        vectors++;
        if ({valid, busy, done, cnt} !== {1'b0, 1'b0, 1'b0, 4'd3}) begin
            miscompares++;
            $display("FAIL load_no_en: got valid=%0b busy=%0b done=%0b cnt=%0d want 0 0 0 3", valid, busy, done, cnt);
        end
        en = 1'b1; d = 8'h00;
        tick();
        load = 1'b0;
        vectors++;
        if ({done, valid, busy, cnt} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL zero_done: got done=%0b valid=%0b busy=%0b cnt=%0d want 1 0 0 0", done, valid, busy, cnt);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pulse: got done=%0b valid=%0b want 0 0", done, valid);
        end
    endtask

    task automatic test_ready_toggle;
        logic [2:0] got [8];
        logic [2:0] hold_y;
        logic [2:0] want;
        logic       hold_chk;
        int         n;
        logic       seen_done;
        do_reset();
        en = 1'b1; load = 1'b1; d = 8'hFF; ready = 1'b0;
        tick();
        load = 1'b0;
        n = 0; hold_chk = 1'b0; hold_y = '0; seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ready = (c % 3 == 0);
            hold_chk = 1'b0;
            if (valid && ready && n < 8) begin
                got[n] = y;
                n++;
            end else if (valid && !ready) begin
                hold_y   = y;
                hold_chk = 1'b1;
            end
            tick();
            if (hold_chk) begin
                vectors++;
                if (y !== hold_y || valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ff_hold: got y=%0d valid=%0b want y=%0d valid=1", y, valid, hold_y);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen_done || n != 8 || cnt !== 4'd8) begin
            miscompares++;
            $display("FAIL ff_done: got done_seen=%0b n=%0d cnt=%0d want 1 8 8", seen_done, n, cnt);
        end
        for (int i = 0; i < 8 && i < n; i++) begin
`ifdef ENC_ROUND_ROBIN_EN
            want = 3'(i);
`else
            want = 3'(7 - i);
`endif
            vectors++;
            if (got[i] !== want) begin
                miscompares++;
                $display("FAIL ff_order%0d: got %0d want %0d", i, got[i], want);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_en_pause;
        logic [2:0] first_y;
        logic [2:0] second_y;
`ifdef ENC_ROUND_ROBIN_EN
        first_y = 3'd3; second_y = 3'd4;
`else
        first_y = 3'd4; second_y = 3'd3;
`endif
        do_reset();
        en = 1'b1; ready = 1'b1; load = 1'b1; d = 8'b0001_1000;
        tick();
        load = 1'b0;
        vectors++;
        if (y !== first_y || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_first: got y=%0d valid=%0b want y=%0d valid=1", y, valid, first_y);
        end
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({valid, busy, y, cnt} !== {1'b0, 1'b1, second_y, 4'd1}) begin
                miscompares++;
                $display("FAIL pause_hold%0d: got valid=%0b busy=%0b y=%0d cnt=%0d want 0 1 %0d 1", i, valid, busy, y, cnt, second_y);
            end
        end
        en = 1'b1;
        tick();
        vectors++;
        if (valid !== 1'b1 || y !== second_y) begin
            miscompares++;
            $display("FAIL pause_resume: got valid=%0b y=%0d want 1 %0d", valid, y, second_y);
        end
        tick();
        vectors++;
        if ({done, valid, busy, cnt} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
            miscompares++;
            $display("FAIL pause_done: got done=%0b valid=%0b busy=%0b cnt=%0d want 1 0 0 2", done, valid, busy, cnt);
        end
    endtask

    task automatic test_midvector;
        logic [2:0] first_y;
        logic [2:0] second_y;
`ifdef ENC_ROUND_ROBIN_EN
        first_y = 3'd0; second_y = 3'd7;
`else
        first_y = 3'd7; second_y = 3'd0;
`endif
        do_reset();
        en = 1'b1; ready = 1'b0; load = 1'b1; d = 8'h81;
        tick();
        d = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({valid, busy, y, cnt} !== {1'b1, 1'b1, first_y, 4'd0}) begin
                miscompares++;
                $display("FAIL mid_load_ignored%0d: got valid=%0b busy=%0b y=%0d cnt=%0d want 1 1 %0d 0", i, valid, busy, y, cnt, first_y);
            end
        end
        load = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0;
        vectors++;
        if ({valid, y, cnt} !== {1'b1, second_y, 4'd1}) begin
            miscompares++;
            $display("FAIL mid_second: got valid=%0b y=%0d cnt=%0d want 1 %0d 1", valid, y, cnt, second_y);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({y, valid, busy, done, cnt} !== 10'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got y=%0d v=%0b b=%0b d=%0b c=%0d want all zero", y, valid, busy, done, cnt);
        end
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_no_done%0d: got done=%0b valid=%0b busy=%0b want 0 0 0", i, done, valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] s;
        int          n;
        logic [5:0]  w81;
`ifdef ENC_ROUND_ROBIN_EN
        w81 = {3'd7, 3'd0};
`else
        w81 = {3'd0, 3'd7};
`endif
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drain(8'h81, s, n);
            vectors++;
            if (n != 2 || s[5:0] !== w81) begin
                miscompares++;
                $display("FAIL b2b_81_%0d: got n=%0d seq=%h want n=2 seq=%h", r, n, s[5:0], w81);
            end
        end
        drain(8'h01, s, n);
        vectors++;
        if (n != 1 || s[2:0] !== 3'd0) begin
            miscompares++;
            $display("FAIL b2b_01: got n=%0d y=%0d want n=1 y=0", n, s[2:0]);
        end
        drain(8'h03, s, n);
        vectors++;
        if (n != 2 || s[5:0] !== {3'd0, 3'd1}) begin
            miscompares++;
            $display("FAIL b2b_03: got n=%0d seq=%h want n=2 seq=%h", n, s[5:0], {3'd0, 3'd1});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_load();
        test_ready_toggle();
        test_en_pause();
        test_midvector();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
